// File: rtl/c432_lock_pkg.sv
// Shared constants, key-field slices and FSM state encoding
// for the c432 key sequencer and its key-store fetch unit.
package c432_lock_pkg;

  localparam int KEY_W  = 34;
  localparam int WORD_W = 8;

  localparam logic [2:0] N_WORDS  = 3'd6;
  localparam logic [2:0] CSUM_IDX = 3'd5;

  localparam logic [7:0] RESERVED_MASK = 8'hFC;

  // p1..p4 MUX selects, then X_1..X_30 XOR key gates
  localparam int P_LSB = 0;
  localparam int P_MSB = 3;
  localparam int X_LSB = 4;
  localparam int X_MSB = 33;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_ARMED,
    S_FAIL,
    S_LOCKOUT
  } state_t;

endpackage

// File: rtl/key_fetch_if.sv
// Key-store read engine: walks words 0..CSUM_IDX over rd_req/rd_ack.
// Ports: launch/abort control, rd_* handshake, word_valid/word_data/timeout.
module key_fetch_if
  import c432_lock_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              launch,
  input  logic              abort,
  input  logic              rd_ack,
  input  logic [WORD_W-1:0] rd_data,
  output logic              rd_req,
  output logic [2:0]        rd_addr,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign word_valid = rd_req & rd_ack;
  assign word_data  = rd_data;

  // fires on the TIMEOUT-th consecutive cycle without an ack
  assign timeout = rd_req & ~rd_ack
                 & (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_req   <= 1'b0;
      rd_addr  <= 3'd0;
      wait_cnt <= '0;
    end else if (abort) begin
      rd_req   <= 1'b0;
      rd_addr  <= 3'd0;
      wait_cnt <= '0;
    end else if (launch) begin
      rd_req   <= 1'b1;
      rd_addr  <= 3'd0;
      wait_cnt <= '0;
    end else if (rd_req) begin
      if (rd_ack) begin
        wait_cnt <= '0;
        if (rd_addr == CSUM_IDX) begin
          rd_req  <= 1'b0;
          rd_addr <= 3'd0;
        end else begin
          rd_addr <= rd_addr + 3'd1;
        end
      end else if (timeout) begin
        rd_req   <= 1'b0;
        rd_addr  <= 3'd0;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/c432_key_sequencer.sv
// Loads, checksums and commits the 34-bit c432 unlock key.
// Ports: start/zeroize, key-store rd_*, key_out/key_valid, busy, fail_cnt, lockout.
module c432_key_sequencer #(
  parameter int KEY_W    = 34,
  parameter int WORD_W   = 8,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              zeroize,
  output logic              rd_req,
  output logic [2:0]        rd_addr,
  input  logic              rd_ack,
  input  logic [WORD_W-1:0] rd_data,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic [1:0]        fail_cnt,
  output logic              lockout
);

  import c432_lock_pkg::*;

  state_t           state;
  logic [KEY_W-1:0] shadow;
  logic [7:0]       acc;
  logic             rsvd_bad;

  logic             launch;
  logic             abort;
  logic             word_valid;
  logic [7:0]       word_data;
  logic             timeout;
  logic [1:0]       fail_nxt;

  assign abort    = zeroize & (state != S_LOCKOUT);
  assign launch   = start & ~abort
                  & ((state == S_IDLE) | (state == S_ARMED));
  assign fail_nxt = fail_cnt + 2'd1;

  key_fetch_if #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch     (launch),
    .abort      (abort),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .word_valid (word_valid),
    .word_data  (word_data),
    .timeout    (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shadow    <= '0;
      acc       <= '0;
      rsvd_bad  <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      fail_cnt  <= 2'd0;
      lockout   <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      shadow    <= '0;
      acc       <= '0;
      rsvd_bad  <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_ARMED: begin
          if (launch) begin
            state    <= S_FETCH;
            shadow   <= '0;
            acc      <= '0;
            rsvd_bad <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (word_valid) begin
            acc <= acc ^ word_data;
            if (rd_addr < 3'd4) begin
              shadow[{rd_addr[1:0], 3'b000} +: 8] <= word_data;
            end else if (rd_addr == 3'd4) begin
              shadow[KEY_W-1:32] <= word_data[1:0];
              rsvd_bad <= |(word_data & RESERVED_MASK);
            end
            if (rd_addr == CSUM_IDX) begin
              state <= S_CHECK;
            end
          end else if (timeout) begin
            state <= S_FAIL;
          end
        end
        S_CHECK: begin
          // acc already folds in word 5, so a match leaves zero
          if ((acc == 8'h00) && !rsvd_bad) begin
            state                <= S_ARMED;
            key_out[P_MSB:P_LSB] <= shadow[P_MSB:P_LSB];
            key_out[X_MSB:X_LSB] <= shadow[X_MSB:X_LSB];
            key_valid            <= 1'b1;
            fail_cnt             <= 2'd0;
            busy                 <= 1'b0;
          end else begin
            state <= S_FAIL;
          end
        end
        S_FAIL: begin
          shadow    <= '0;
          key_out   <= '0;
          key_valid <= 1'b0;
          busy      <= 1'b0;
          fail_cnt  <= fail_nxt;
          if (fail_nxt == 2'(MAX_FAIL)) begin
            state   <= S_LOCKOUT;
            lockout <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          key_out   <= '0;
          key_valid <= 1'b0;
          lockout   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
